// File: rtl/midori64_iter_core.sv
// Iterative Midori64 encrypt/decrypt core with valid/ready handshakes on both sides.
// ROUNDS_PER_CYCLE combinational rounds are chained per clock; round keys are derived on the fly.

module midori64_iter_core #(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter int NUM_ROUNDS       = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         enc,
   input  logic [127:0] key,
   input  logic [63:0]  indata,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  outdata,
   output logic         busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [4:0] RPC    = 5'(ROUNDS_PER_CYCLE);
   localparam logic [4:0] LAST   = 5'(NUM_ROUNDS);

   if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 3 || ROUNDS_PER_CYCLE == 5 ||
         ROUNDS_PER_CYCLE == 15) || NUM_ROUNDS != 15) begin : g_bad_param
      $error("midori64_iter_core: ROUNDS_PER_CYCLE must be 1, 3, 5 or 15 and NUM_ROUNDS 15");
   end

   // Sb0 is an involution, so the same S-box serves encryption and decryption.
   function automatic logic [3:0] sb0(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;  4'h1: y = 4'hA;  4'h2: y = 4'hD;  4'h3: y = 4'h3;
         4'h4: y = 4'hE;  4'h5: y = 4'hB;  4'h6: y = 4'hF;  4'h7: y = 4'h7;
         4'h8: y = 4'h8;  4'h9: y = 4'h9;  4'hA: y = 4'h1;  4'hB: y = 4'h5;
         4'hC: y = 4'h0;  4'hD: y = 4'h2;  4'hE: y = 4'h4;  default: y = 4'h6;
      endcase
      return y;
   endfunction

   function automatic logic [63:0] sub_cells(input logic [63:0] s);
      logic [63:0] r;
      for (int i = 0; i < 16; i++) r[4*i +: 4] = sb0(s[4*i +: 4]);
      return r;
   endfunction

   // Cell c occupies bits [63-4c -: 4]; output cell i takes input cell perm[i].
   function automatic logic [63:0] shuffle_cells(input logic [63:0] s);
      return {s[63:60], s[23:20], s[43:40], s[3:0],   s[7:4],   s[47:44], s[19:16], s[59:56],
              s[27:24], s[51:48], s[15:12], s[39:36], s[35:32], s[11:8],  s[55:52], s[31:28]};
   endfunction

   function automatic logic [63:0] inv_shuffle_cells(input logic [63:0] s);
      return {s[63:60], s[35:32], s[7:4],   s[27:24], s[43:40], s[55:52], s[19:16], s[15:12],
              s[3:0],   s[31:28], s[59:56], s[39:36], s[23:20], s[11:8],  s[47:44], s[51:48]};
   endfunction

   // Each output cell is the XOR of the other three cells of its column.
   function automatic logic [63:0] mix_columns(input logic [63:0] s);
      logic [63:0] r;
      logic [15:0] col;
      logic [3:0]  t;
      for (int c = 0; c < 4; c++) begin
         col = s[63-16*c -: 16];
         t   = col[15:12] ^ col[11:8] ^ col[7:4] ^ col[3:0];
         r[63-16*c -: 16] = {4{t}} ^ col;
      end
      return r;
   endfunction

   // Bit 15 of each constant belongs to cell 0.
   function automatic logic [15:0] beta(input logic [3:0] idx);
      logic [15:0] b;
      case (idx)
         4'd0:  b = 16'h15B3;  4'd1:  b = 16'h78C0;  4'd2:  b = 16'hA435;  4'd3:  b = 16'h6213;
         4'd4:  b = 16'h104F;  4'd5:  b = 16'hD170;  4'd6:  b = 16'h0266;  4'd7:  b = 16'h0BCC;
         4'd8:  b = 16'h9481;  4'd9:  b = 16'h40B8;  4'd10: b = 16'h7197;  4'd11: b = 16'h228E;
         4'd12: b = 16'h5130;  4'd13: b = 16'hF8CA;  4'd14: b = 16'hDF90;  default: b = 16'h0000;
      endcase
      return b;
   endfunction

   function automatic logic [63:0] round_key(input logic [127:0] k, input logic [3:0] idx);
      logic [15:0] b;
      logic [63:0] rk;
      b  = beta(idx);
      rk = idx[0] ? k[63:0] : k[127:64];
      for (int j = 0; j < 16; j++) rk[4*j] = rk[4*j] ^ b[j];
      return rk;
   endfunction

   function automatic logic [63:0] midori_round(input logic is_enc, input logic [63:0] s,
                                                input logic [63:0] rk);
      logic [63:0] sb;
      sb = sub_cells(s);
      return (is_enc ? mix_columns(shuffle_cells(sb)) : inv_shuffle_cells(mix_columns(sb))) ^ rk;
   endfunction

   logic [1:0]   r_fsm;
   logic         r_enc;
   logic [127:0] r_key;
   logic [63:0]  r_data;
   logic [3:0]   r_cnt;
   logic [63:0]  r_out;
   logic         r_out_valid;

   logic [63:0]  w_wk;
   logic [63:0]  w_in_wk;
   logic [4:0]   w_cnt_next;
   logic [63:0]  w_chain [0:ROUNDS_PER_CYCLE];

   assign w_wk       = r_key[127:64] ^ r_key[63:0];
   assign w_in_wk    = key[127:64] ^ key[63:0];
   assign w_cnt_next = {1'b0, r_cnt} + RPC;
   assign w_chain[0] = r_data;

   // Decryption runs the rounds in reverse and needs the round key pulled back through L^-1.
   for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
      logic [3:0]  w_idx;
      logic [63:0] w_rk;
      assign w_idx = r_cnt + 4'(g);
      assign w_rk  = r_enc ? round_key(r_key, w_idx)
                           : inv_shuffle_cells(mix_columns(round_key(r_key, 4'd14 - w_idx)));
      assign w_chain[g+1] = midori_round(r_enc, w_chain[g], w_rk);
   end

   // NOTE: registers update with non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm       <= S_IDLE;
         r_enc       <= 1'b0;
         r_key       <= '0;
         r_data      <= '0;
         r_cnt       <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_fsm)
            S_IDLE: begin
               if (in_valid) begin
                  r_enc  <= enc;
                  r_key  <= key;
                  r_data <= indata ^ w_in_wk;
                  r_cnt  <= '0;
                  r_fsm  <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_cnt_next == LAST) begin
                  r_out       <= sub_cells(w_chain[ROUNDS_PER_CYCLE]) ^ w_wk;
                  r_out_valid <= 1'b1;
                  r_fsm       <= S_DONE;
               end else begin
                  r_data <= w_chain[ROUNDS_PER_CYCLE];
                  r_cnt  <= w_cnt_next[3:0];
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_fsm       <= S_IDLE;
               end
            end
            default: r_fsm <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_fsm == S_IDLE);
   assign busy      = (r_fsm != S_IDLE);
   assign out_valid = r_out_valid;
   assign outdata   = r_out;

endmodule

// File: tb/tb_midori64_iter_core.sv
// Directed bench for midori64_iter_core: known vectors on every unroll depth, handshake,
// reset and input-churn scenarios, plus a randomized back-to-back run against a cell-level model.

module tb_midori64_iter_core;

   localparam logic [127:0] KAT_KEY = 128'h687ded3b3c85b3f35b1009863e2a8cbf;
   localparam logic [63:0]  KAT_PT  = 64'h42c20fd3b586879e;
   localparam logic [63:0]  KAT_CT  = 64'h66bcdc6270d901cd;
   localparam logic [63:0]  ZERO_CT = 64'h3c9cceda2bbd449a;

   localparam logic [63:0] SBOX = 64'hCAD3EBF789150246;
   localparam logic [63:0] PERM = 64'h0A5FE4B193C67D28;
   localparam logic [15:0] BETA [15] = '{16'h15B3, 16'h78C0, 16'hA435, 16'h6213, 16'h104F,
                                         16'hD170, 16'h0266, 16'h0BCC, 16'h9481, 16'h40B8,
                                         16'h7197, 16'h228E, 16'h5130, 16'hF8CA, 16'hDF90};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         enc;
   logic [127:0] key;
   logic [63:0]  indata;
   logic [3:0]   in_valid, in_ready, out_valid, out_ready, busy;
   logic [63:0]  outdata [4];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   midori64_iter_core #(.ROUNDS_PER_CYCLE(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .enc(enc),
      .key(key), .indata(indata), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .outdata(outdata[0]), .busy(busy[0]));
   midori64_iter_core #(.ROUNDS_PER_CYCLE(3)) u_rpc3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .enc(enc),
      .key(key), .indata(indata), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .outdata(outdata[1]), .busy(busy[1]));
   midori64_iter_core #(.ROUNDS_PER_CYCLE(5)) u_rpc5 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .enc(enc),
      .key(key), .indata(indata), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .outdata(outdata[2]), .busy(busy[2]));
   midori64_iter_core #(.ROUNDS_PER_CYCLE(15)) u_rpc15 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .enc(enc),
      .key(key), .indata(indata), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
      .outdata(outdata[3]), .busy(busy[3]));

   // ---------------- reference model, cell-array style ----------------
   function automatic logic [63:0] m_sub(input logic [63:0] s);
      logic [63:0] r;
      int v;
      for (int c = 0; c < 16; c++) begin
         v = int'(s[63-4*c -: 4]);
         r[63-4*c -: 4] = SBOX[63-4*v -: 4];
      end
      return r;
   endfunction

   function automatic logic [63:0] m_shuf(input logic [63:0] s);
      logic [63:0] r;
      int p;
      for (int i = 0; i < 16; i++) begin
         p = int'(PERM[63-4*i -: 4]);
         r[63-4*i -: 4] = s[63-4*p -: 4];
      end
      return r;
   endfunction

   function automatic logic [63:0] m_ishuf(input logic [63:0] s);
      logic [63:0] r;
      int p;
      for (int i = 0; i < 16; i++) begin
         p = int'(PERM[63-4*i -: 4]);
         r[63-4*p -: 4] = s[63-4*i -: 4];
      end
      return r;
   endfunction

   function automatic logic [63:0] m_mix(input logic [63:0] s);
      logic [63:0] r;
      logic [3:0]  acc;
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) begin
            acc = 4'h0;
            for (int j = 0; j < 4; j++)
               if (j != k) acc = acc ^ s[63-4*(4*c+j) -: 4];
            r[63-4*(4*c+k) -: 4] = acc;
         end
      end
      return r;
   endfunction

   function automatic logic [63:0] m_rk(input logic [127:0] k, input int i);
      logic [63:0] b;
      logic [15:0] bt;
      b  = (i % 2 == 0) ? k[127:64] : k[63:0];
      bt = BETA[i];
      for (int c = 0; c < 16; c++) b[60-4*c] = b[60-4*c] ^ bt[15-c];
      return b;
   endfunction

   function automatic logic [63:0] model_enc(input logic [127:0] k, input logic [63:0] p);
      logic [63:0] wk, s;
      wk = k[127:64] ^ k[63:0];
      s  = p ^ wk;
      for (int i = 0; i < 15; i++) s = m_mix(m_shuf(m_sub(s))) ^ m_rk(k, i);
      return m_sub(s) ^ wk;
   endfunction

   function automatic logic [63:0] model_dec(input logic [127:0] k, input logic [63:0] c);
      logic [63:0] wk, s;
      wk = k[127:64] ^ k[63:0];
      s  = c ^ wk;
      for (int i = 14; i >= 0; i--) s = m_ishuf(m_mix(m_sub(s))) ^ m_ishuf(m_mix(m_rk(k, i)));
      return m_sub(s) ^ wk;
   endfunction

   // ---------------- stimulus helpers ----------------
   // NOTE: inputs change #1 after the rising edge and outputs are read there, never on the edge.
   task automatic accept_main(input logic e, input logic [127:0] k, input logic [63:0] d);
      int n;
      enc = e; key = k; indata = d; in_valid[0] = 1'b1;
      n = 0;
      while (!in_ready[0] && n < 100) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
   endtask

   task automatic wait_out(output int lat, input bit churn);
      lat = 0;
      while (!out_valid[0] && lat < 100) begin
         @(posedge clk); #1; lat++;
         if (churn) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            indata = {$urandom, $urandom};
            enc = 1'($urandom_range(0, 1));
         end
      end
   endtask

   task automatic consume_main;
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst_n = 1'b0; in_valid = '0; out_ready = '0; enc = 1'b1; key = '0; indata = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
         total++;
         if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags[%0d]: got rdy=%b vld=%b busy=%b exp 1 0 0",
                     d, in_ready[d], out_valid[d], busy[d]);
         end
         total++;
         if (outdata[d] !== 64'h0) begin
            bad++;
            $display("FAIL reset_outdata[%0d]: got %h exp 0", d, outdata[d]);
         end
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_latency_all_rpc;
      int exp_lat [4] = '{15, 5, 3, 1};
      int lat [4]     = '{0, 0, 0, 0};
      enc = 1'b1; key = '0; indata = '0; in_valid = 4'hF; out_ready = '0;
      @(posedge clk); #1;
      in_valid = '0;
      total++;
      if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
         bad++;
         $display("FAIL accept_busy: got busy=%b rdy=%b exp 1 0", busy[0], in_ready[0]);
      end
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 4; d++)
            if (out_valid[d] && lat[d] == 0) lat[d] = e;
      end
      for (int d = 0; d < 4; d++) begin
         total++;
         if (lat[d] != exp_lat[d]) begin
            bad++;
            $display("FAIL latency[%0d]: got %0d exp %0d", d, lat[d], exp_lat[d]);
         end
         total++;
         if (outdata[d] !== ZERO_CT) begin
            bad++;
            $display("FAIL zero_vector[%0d]: got %h exp %h", d, outdata[d], ZERO_CT);
         end
      end
      out_ready = 4'hF;
      @(posedge clk); #1;
      out_ready = '0;
      for (int d = 0; d < 4; d++) begin
         total++;
         if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
            bad++;
            $display("FAIL release[%0d]: got vld=%b rdy=%b exp 0 1", d, out_valid[d], in_ready[d]);
         end
      end
   endtask

   task automatic test_known_vectors;
      int lat;
      accept_main(1'b1, KAT_KEY, KAT_PT);
      wait_out(lat, 1'b0);
      total++;
      if (outdata[0] !== KAT_CT || lat != 15) begin
         bad++;
         $display("FAIL kat_encrypt: got %h lat=%0d exp %h lat=15", outdata[0], lat, KAT_CT);
      end
      consume_main();
      accept_main(1'b0, KAT_KEY, KAT_CT);
      wait_out(lat, 1'b0);
      total++;
      if (outdata[0] !== KAT_PT || lat != 15) begin
         bad++;
         $display("FAIL kat_decrypt: got %h lat=%0d exp %h lat=15", outdata[0], lat, KAT_PT);
      end
      consume_main();
      accept_main(1'b0, 128'h0, ZERO_CT);
      wait_out(lat, 1'b0);
      total++;
      if (outdata[0] !== 64'h0) begin
         bad++;
         $display("FAIL zero_decrypt: got %h exp 0", outdata[0]);
      end
      consume_main();
   endtask

   task automatic test_backpressure;
      int lat;
      accept_main(1'b1, KAT_KEY, KAT_PT);
      wait_out(lat, 1'b0);
      for (int i = 0; i < 20; i++) begin
         in_valid[0] = 1'(i % 2);
         indata = {$urandom, $urandom};
         key = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
         total++;
         if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || busy[0] !== 1'b1 ||
             outdata[0] !== KAT_CT) begin
            bad++;
            $display("FAIL backpressure_hold[%0d]: got vld=%b rdy=%b busy=%b out=%h exp 1 0 1 %h",
                     i, out_valid[0], in_ready[0], busy[0], outdata[0], KAT_CT);
         end
      end
      in_valid[0] = 1'b0;
      consume_main();
      total++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0 ||
          outdata[0] !== KAT_CT) begin
         bad++;
         $display("FAIL backpressure_release: got vld=%b rdy=%b busy=%b out=%h exp 0 1 0 %h",
                  out_valid[0], in_ready[0], busy[0], outdata[0], KAT_CT);
      end
      @(posedge clk); #1;
      total++;
      if (busy[0] !== 1'b0) begin
         bad++;
         $display("FAIL backpressure_idle: got busy=%b exp 0", busy[0]);
      end
   endtask

   task automatic test_reset_mid_run;
      int lat;
      accept_main(1'b1, KAT_KEY, KAT_PT);
      repeat (6) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid[0] !== 1'b0 || outdata[0] !== 64'h0 || busy[0] !== 1'b0 ||
          in_ready[0] !== 1'b1) begin
         bad++;
         $display("FAIL async_reset: got vld=%b out=%h busy=%b rdy=%b exp 0 0 0 1",
                  out_valid[0], outdata[0], busy[0], in_ready[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
         bad++;
         $display("FAIL abandoned_block: got vld=%b busy=%b exp 0 0", out_valid[0], busy[0]);
      end
      accept_main(1'b1, KAT_KEY, KAT_PT);
      wait_out(lat, 1'b0);
      total++;
      if (outdata[0] !== KAT_CT) begin
         bad++;
         $display("FAIL after_reset_encrypt: got %h exp %h", outdata[0], KAT_CT);
      end
      consume_main();
   endtask

   task automatic test_input_churn;
      int lat;
      accept_main(1'b1, KAT_KEY, KAT_PT);
      wait_out(lat, 1'b1);
      total++;
      if (outdata[0] !== KAT_CT || lat != 15) begin
         bad++;
         $display("FAIL churn_encrypt: got %h lat=%0d exp %h lat=15", outdata[0], lat, KAT_CT);
      end
      consume_main();
      accept_main(1'b0, KAT_KEY, KAT_CT);
      wait_out(lat, 1'b1);
      total++;
      if (outdata[0] !== KAT_PT || lat != 15) begin
         bad++;
         $display("FAIL churn_decrypt: got %h lat=%0d exp %h lat=15", outdata[0], lat, KAT_PT);
      end
      consume_main();
   endtask

   task automatic test_back_to_back;
      logic [63:0] exp_q [$];
      logic [63:0] cur_exp, seen, want;
      logic        accept, consume;
      int          sent, got, cyc;
      sent = 0; got = 0; cyc = 0; cur_exp = '0;
      in_valid[0] = 1'b0; out_ready[0] = 1'b0;
      while (got < 100 && cyc < 20000) begin
         if (!in_valid[0] && sent < 100) begin
            enc     = 1'($urandom_range(0, 1));
            key     = {$urandom, $urandom, $urandom, $urandom};
            indata  = {$urandom, $urandom};
            cur_exp = enc ? model_enc(key, indata) : model_dec(key, indata);
            in_valid[0] = 1'b1;
         end
         out_ready[0] = 1'($urandom_range(0, 1));
         accept  = in_valid[0] & in_ready[0];
         consume = out_valid[0] & out_ready[0];
         seen    = outdata[0];
         @(posedge clk); #1;
         cyc++;
         if (accept) begin
            exp_q.push_back(cur_exp);
            sent++;
            in_valid[0] = 1'b0;
         end
         if (consume) begin
            got++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL b2b_extra_output: got %h with no pending request", seen);
            end else begin
               want = exp_q.pop_front();
               if (seen !== want) begin
                  bad++;
                  $display("FAIL b2b_block[%0d]: got %h exp %h", got - 1, seen, want);
               end
            end
         end
      end
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      out_ready[0] = 1'b0;
      total++;
      if (got != 100 || sent != 100 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL b2b_counts: got sent=%0d recv=%0d pending=%0d exp 100 100 0",
                  sent, got, exp_q.size());
      end
      total++;
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
         bad++;
         $display("FAIL b2b_drain: got vld=%b busy=%b exp 0 0", out_valid[0], busy[0]);
      end
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_latency_all_rpc();
      test_known_vectors();
      test_backpressure();
      test_reset_mid_run();
      test_input_churn();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
